// File: rtl/vga_frame_pkg.sv
// Shared types and constants for the VGA frame reader: FSM encoding and frame size helper.
package vga_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRAME_START,
        ST_FETCH,
        ST_DRAIN,
        ST_FRAME_END
    } state_t;

    localparam int BYTES_PER_PIX = 4;

    function automatic int npix(input int h_disp, input int v_disp);
        return h_disp * v_disp;
    endfunction

endpackage

// File: rtl/vga_pixel_fifo.sv
// Show-ahead pixel FIFO: rd_data always presents the head word, used reports occupancy.
module vga_pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] used
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_rd;

    assign empty   = (used == '0);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Writer never overruns: the frame reader only issues reads it has room for.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, do_rd})
                2'b10:   used <= used + (AW+1)'(1);
                2'b01:   used <= used - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/vga_frame_reader.sv
// Avalon-MM framebuffer reader feeding an Avalon-ST pixel stream, one frame per packet,
// with double buffering that only swaps on frame boundaries.
//
// state          | meaning
// ST_IDLE        | stream stopped, no reads
// ST_FRAME_START | latch front buffer base, clear frame counters
// ST_FETCH       | issue reads while credit allows
// ST_DRAIN       | all reads issued, wait for last pixel to leave
// ST_FRAME_END   | apply pending swap, restart or stop
module vga_frame_reader
    import vga_frame_pkg::*;
#(
    parameter int H_DISP     = 640,
    parameter int V_DISP     = 480,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] base_addr_a,
    input  logic [ADDR_W-1:0] base_addr_b,
    input  logic              swap_req,
    output logic              front_sel,
    output logic              swap_done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [31:0]       st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop,
    output logic [1:0]        st_empty
);
    localparam int NPIX = npix(H_DISP, V_DISP);
    localparam int CW   = $clog2(NPIX + 1);
    localparam int FW   = $clog2(FIFO_DEPTH);

    state_t          state, state_nx;
    logic [CW-1:0]   rd_cnt, px_cnt;
    logic [FW:0]     outstanding, fifo_used;
    logic [FW+1:0]   credit;
    logic [ADDR_W-1:0] addr;
    logic            pending, fifo_empty, accept, xfer, last_px;

    // Words in flight count against FIFO space so returning data always fits.
    assign credit      = {1'b0, fifo_used} + {1'b0, outstanding};
    assign avm_read    = (state == ST_FETCH) && (rd_cnt < CW'(NPIX))
                         && (credit < (FW+2)'(FIFO_DEPTH));
    assign avm_address = addr;
    assign accept      = avm_read && !avm_waitrequest;

    assign st_valid  = !fifo_empty;
    assign xfer      = st_valid && st_ready;
    assign last_px   = (px_cnt == CW'(NPIX - 1));
    assign st_sop    = st_valid && (px_cnt == '0);
    assign st_eop    = st_valid && last_px;
    assign st_empty  = 2'b00;
    assign swap_done = (state == ST_FRAME_END) && pending;

    vga_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (avm_readdatavalid),
        .wr_data (avm_readdata),
        .rd_en   (xfer),
        .rd_data (st_data),
        .empty   (fifo_empty),
        .used    (fifo_used)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:        if (enable) state_nx = ST_FRAME_START;
            ST_FRAME_START: state_nx = ST_FETCH;
            ST_FETCH: begin
                if (rd_cnt == CW'(NPIX))
                    state_nx = (xfer && last_px) ? ST_FRAME_END : ST_DRAIN;
            end
            ST_DRAIN:       if (xfer && last_px) state_nx = ST_FRAME_END;
            ST_FRAME_END:   state_nx = enable ? ST_FRAME_START : ST_IDLE;
            default:        state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt      <= '0;
            px_cnt      <= '0;
            outstanding <= '0;
            addr        <= '0;
            front_sel   <= 1'b0;
            pending     <= 1'b0;
        end else begin
            if (state == ST_FRAME_START) begin
                addr   <= front_sel ? base_addr_b : base_addr_a;
                rd_cnt <= '0;
            end else if (accept) begin
                addr   <= addr + ADDR_W'(BYTES_PER_PIX);
                rd_cnt <= rd_cnt + CW'(1);
            end

            if (state == ST_FRAME_START) px_cnt <= '0;
            else if (xfer)               px_cnt <= px_cnt + CW'(1);

            case ({accept, avm_readdatavalid})
                2'b10:   outstanding <= outstanding + (FW+1)'(1);
                2'b01:   outstanding <= outstanding - (FW+1)'(1);
                default: ;
            endcase

            // A request landing on the boundary cycle is kept for the next frame.
            if (state == ST_FRAME_END) begin
                pending <= swap_req;
                if (pending) front_sel <= ~front_sel;
            end else if (swap_req) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Randomized scoreboard bench: a frame is expected to be NPIX consecutive words of the
// currently selected buffer, with the memory model returning each word's own address.
module tb_vga_frame_reader;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int NP = H * V;
    localparam int FD = 16;

    logic        clk = 0;
    logic        reset_n = 0;
    logic        enable = 0;
    logic [31:0] base_addr_a = 32'h0010_0000;
    logic [31:0] base_addr_b = 32'h0020_0000;
    logic        swap_req = 0;
    logic        front_sel, swap_done;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 0;
    logic [31:0] avm_readdata = 0;
    logic        avm_readdatavalid = 0;
    logic [31:0] st_data;
    logic        st_valid, st_sop, st_eop;
    logic        st_ready = 1;
    logic [1:0]  st_empty;

    vga_frame_reader #(.H_DISP(H), .V_DISP(V), .ADDR_W(32), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .base_addr_a(base_addr_a), .base_addr_b(base_addr_b),
        .swap_req(swap_req), .front_sel(front_sel), .swap_done(swap_done),
        .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .st_sop(st_sop), .st_eop(st_eop), .st_empty(st_empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t exp_q[$];

    task automatic push_frame(input logic [31:0] base);
        for (int i = 0; i < NP; i++)
            exp_q.push_back('{data: base + 32'(4 * i), sop: (i == 0), eop: (i == NP - 1)});
    endtask

    // ---------------- monitor ----------------
    int    beat_idx = 0, eop_cnt = 0, swap_cnt = 0, acc = 0, pops = 0;
    logic  prev_stall = 0;
    logic [31:0] prev_addr = 0;
    beat_t mon_e;

    always @(negedge clk) begin
        if (!reset_n) begin
            beat_idx = 0; eop_cnt = 0; swap_cnt = 0; acc = 0; pops = 0; prev_stall = 0;
        end else begin
            n_checks++;
            if (acc - pops > FD) begin
                n_fail++;
                $display("FAIL credit: fifo_used+outstanding %0d, limit %0d", acc - pops, FD);
            end
            if (prev_stall) begin
                check("wait_hold_read", 32'(avm_read), 32'd1);
                check("wait_hold_addr", avm_address, prev_addr);
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            if (avm_read && !avm_waitrequest) acc++;
            if (swap_done) swap_cnt++;
            if (st_valid && st_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_beat: got data 0x%08h, expected no beat", st_data);
                    beat_idx++;
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pixel_data", st_data, mon_e.data);
                    check("sop", 32'(st_sop), 32'(mon_e.sop));
                    check("eop", 32'(st_eop), 32'(mon_e.eop));
                    check("st_empty", 32'(st_empty), 32'd0);
                    if (mon_e.eop) begin beat_idx = 0; eop_cnt++; end
                    else beat_idx++;
                end
            end
        end
    end

    // ---------------- memory slave and sink driver ----------------
    typedef struct { logic [31:0] addr; int due; } rsp_t;
    rsp_t pend[$];
    int   cyc = 0, last_due = 0, stall_left = 0, force_skip = -1, seen_seq = 0, d = 0;
    int   wait_seq = 0, ready_mode = 0;
    bit   rand_wait = 0, rand_lat = 0, wt = 0;

    initial begin
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!reset_n) begin
                pend.delete();
                stall_left = 0; force_skip = -1;
                avm_waitrequest = 0; avm_readdatavalid = 0;
            end else begin
                if (wait_seq != seen_seq) begin seen_seq = wait_seq; force_skip = 2; end
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    avm_readdatavalid = 1;
                    avm_readdata = pend[0].addr;
                    void'(pend.pop_front());
                end else begin
                    avm_readdatavalid = 0;
                    avm_readdata = $urandom;
                end
                wt = 0;
                if (avm_read) begin
                    if (stall_left > 0) begin wt = 1; stall_left--; end
                    else if (force_skip == 0) begin wt = 1; stall_left = 4; force_skip = -1; end
                    else if (rand_wait) wt = ($urandom_range(0, 3) == 0);
                end
                avm_waitrequest = wt;
                if (avm_read && !wt) begin
                    d = cyc + 1 + (rand_lat ? int'($urandom_range(0, 3)) : 0);
                    if (d < last_due) d = last_due;
                    last_due = d;
                    pend.push_back('{addr: avm_address, due: d});
                    if (force_skip > 0) force_skip--;
                end
            end
            case (ready_mode)
                0:       st_ready = 1;
                1:       st_ready = 0;
                default: st_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ---------------- stimulus ----------------
    bit model_front = 0;
    int n_swaps = 0, eops = 0, acc_mark = 0, which = 0;
    bit do_swap = 0;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_eop(input int target);
        int n = 0;
        while (eop_cnt < target && n < 3000) begin tick(); n++; end
        if (eop_cnt < target) begin
            n_checks++; n_fail++;
            $display("FAIL eop_timeout: eop count %0d, required %0d", eop_cnt, target);
        end
    endtask

    task automatic wait_beat(input int b);
        int n = 0;
        while (beat_idx < b && n < 3000) begin tick(); n++; end
        if (beat_idx < b) begin
            n_checks++; n_fail++;
            $display("FAIL beat_timeout: beat %0d, required %0d", beat_idx, b);
        end
    endtask

    task automatic pulse_swap();
        swap_req = 1; tick(); swap_req = 0;
    endtask

    task automatic end_frame(input bit swapped, input bit cont, input bit arm_wait);
        eops++;
        wait_eop(eops);
        if (arm_wait) wait_seq++;
        check("reads_per_frame", 32'(acc - acc_mark), 32'(NP));
        acc_mark = acc;
        if (swapped) begin model_front = !model_front; n_swaps++; end
        if (cont) push_frame(model_front ? base_addr_b : base_addr_a);
        tick(); tick();
        check("swap_done_count", 32'(swap_cnt), 32'(n_swaps));
        check("front_sel", 32'(front_sel), 32'(model_front));
    endtask

    initial begin
        repeat (5) tick();
        reset_n = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_read", 32'(avm_read), 0);
            check("idle_valid", 32'(st_valid), 0);
            check("idle_front", 32'(front_sel), 0);
            check("idle_swap_done", 32'(swap_done), 0);
        end

        // two plain frames from buffer A
        push_frame(base_addr_a);
        enable = 1;
        end_frame(0, 1, 0);
        end_frame(0, 1, 0);

        // long sink backpressure mid-frame; next frame gets a 5-cycle stall on its 3rd read
        wait_beat(6);
        ready_mode = 1;
        repeat (100) tick();
        ready_mode = 0;
        end_frame(0, 1, 1);
        end_frame(0, 1, 0);

        // two swap requests in one frame give exactly one swap
        wait_beat(10); pulse_swap();
        wait_beat(20); pulse_swap();
        end_frame(1, 1, 0);
        end_frame(0, 1, 0);

        // randomized traffic with mid-frame base changes and swaps
        rand_wait = 1; rand_lat = 1; ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            do_swap = 1'($urandom_range(0, 1));
            which = int'($urandom_range(0, 2));
            wait_beat(4);
            if (which == 1) base_addr_a = $urandom & 32'hFFFF_FFFC;
            else if (which == 2) base_addr_b = $urandom & 32'hFFFF_FFFC;
            wait_beat(12);
            if (do_swap) pulse_swap();
            end_frame(do_swap, 1, 0);
        end

        // enable dropped mid-frame: frame completes, then stream stops
        wait_beat(5);
        enable = 0;
        end_frame(0, 0, 0);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("stopped_read", 32'(avm_read), 0);
            check("stopped_valid", 32'(st_valid), 0);
        end
        push_frame(model_front ? base_addr_b : base_addr_a);
        enable = 1;
        do_swap = !model_front;
        wait_beat(10);
        if (do_swap) pulse_swap();
        end_frame(do_swap, 1, 0);

        // reset in the middle of a frame showing buffer B
        wait_beat(15);
        reset_n = 0;
        #1;
        check("rst_read", 32'(avm_read), 0);
        check("rst_valid", 32'(st_valid), 0);
        check("rst_front", 32'(front_sel), 0);
        check("rst_sop", 32'(st_sop), 0);
        check("rst_swap_done", 32'(swap_done), 0);
        exp_q.delete();
        model_front = 0; n_swaps = 0; eops = 0; acc_mark = 0;
        repeat (3) tick();
        push_frame(base_addr_a);
        reset_n = 1;
        wait_beat(3);
        enable = 0;
        end_frame(0, 0, 0);
        repeat (10) tick();
        check("leftover_beats", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
